// File: rtl/mc1_pkg.sv
// rtl/mc1_pkg.sv - shared types and constants for the MC1 sweep controller
// Purpose: sweep FSM state encoding and the MC1 golden truth table.
// Ports: none (package).
package mc1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // F(A,B,C,D) = PI M(0,1,2,8,10,12,14); bit i = F(i), i = {A,B,C,D}
    localparam logic [15:0] MC1_TRUTH = 16'hAAF8;
    localparam int unsigned MC1_NVEC  = 16;

endpackage

// File: rtl/mc1_settle_timer.sv
// rtl/mc1_settle_timer.sv - loadable down-counter timing each vector's settle window
// Purpose: counts the settle cycles of one vector; o_expire marks the last one.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset
//   i_load   in  1  reload the counter with LOAD_VAL
//   i_en     in  1  count enable (high while settling)
//   o_expire out 1  high on the final enabled cycle of the window
module mc1_settle_timer #(
    parameter int unsigned LOAD_VAL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    // At least one bit, even when the window is a single cycle (LOAD_VAL = 0).
    localparam int unsigned CW = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(LOAD_VAL);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/mc1_sweep_ctrl.sv
// rtl/mc1_sweep_ctrl.sv - self-check sequencer sweeping all 16 inputs of MC1
// Purpose: drives ABCD = 0..15 into MC1, lets each settle, samples F, compares it
//          against the golden truth table and reports pass/fail and diagnostics.
// Ports:
//   clk            in  1   rising-edge clock
//   rst_n          in  1   asynchronous active-low reset
//   start          in  1   request a sweep (honoured only in IDLE)
//   abort          in  1   cancel the sweep in progress
//   dut_in         out 4   {A,B,C,D} driven to MC1
//   dut_f          in  1   MC1 output F
//   busy           out 1   sweep in progress
//   done           out 1   one-cycle pulse on sweep completion
//   pass           out 1   last completed sweep had no mismatches
//   err_count      out 5   mismatch count, 0..16
//   first_fail_vld out 1   a mismatch has been seen
//   first_fail_idx out 4   lowest mismatching vector
//   result_vec     out 16  sampled F values, bit i = F(i)
module mc1_sweep_ctrl
    import mc1_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] EXP_MASK   = MC1_TRUTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  dut_in,
    input  logic        dut_f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic        first_fail_vld,
    output logic [3:0]  first_fail_idx,
    output logic [15:0] result_vec
);

    localparam logic [3:0] LAST_IDX = 4'(MC1_NVEC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_idx;
    logic        w_start_ok;
    logic        w_sample_ok;
    logic        w_abort_ok;
    logic        w_timer_load;
    logic        w_expire;

    assign w_start_ok   = (r_state == ST_IDLE) && start && !abort;
    assign w_abort_ok   = abort && ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE));
    // An abort in the sampling cycle wins: that vector is not recorded.
    assign w_sample_ok  = (r_state == ST_SAMPLE) && !abort;
    // Reload on every entry into SETTLE so each vector gets a full window.
    assign w_timer_load = (w_next == ST_SETTLE) && (r_state != ST_SETTLE);

    mc1_settle_timer #(
        .LOAD_VAL (SETTLE_CYC - 1)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_timer_load),
        .i_en     (r_state == ST_SETTLE),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        dut_in = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy   = 1'b1;
                dut_in = r_idx;
                if (abort)         w_next = ST_IDLE;
                else if (w_expire) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                busy   = 1'b1;
                dut_in = r_idx;
                if (abort)                  w_next = ST_IDLE;
                else if (r_idx == LAST_IDX) w_next = ST_DONE;
                else                        w_next = ST_SETTLE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Scoreboard: results persist after DONE/abort and are cleared on the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= 4'd0;
            err_count      <= 5'd0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= 4'd0;
            result_vec     <= 16'd0;
            pass           <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_idx          <= 4'd0;
                err_count      <= 5'd0;
                first_fail_vld <= 1'b0;
                first_fail_idx <= 4'd0;
                result_vec     <= 16'd0;
                pass           <= 1'b0;
            end
            if (w_sample_ok) begin
                result_vec[r_idx] <= dut_f;
                if (dut_f != EXP_MASK[r_idx]) begin
                    err_count <= err_count + 5'd1;
                    if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= r_idx;
                    end
                end
                if (r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
            end
            // err_count already includes the final sample by the time DONE is reached.
            if (r_state == ST_DONE) pass <= (err_count == 5'd0);
            if (w_abort_ok)         pass <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mc1_sweep_ctrl.sv
// tb/tb_mc1_sweep_ctrl.sv - self-checking bench for mc1_sweep_ctrl
module tb_mc1_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  dut_in;
    logic        dut_f;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic        first_fail_vld;
    logic [3:0]  first_fail_idx;
    logic [15:0] result_vec;

    int n_checks = 0;
    int n_errors = 0;
    int mode = 0;   // 0 golden, 1 stuck-0, 2 inverted, 3 stuck-1, 4 wrong only at vector 15

    always #5 clk = ~clk;

    mc1_sweep_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dut_in         (dut_in),
        .dut_f          (dut_f),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx),
        .result_vec     (result_vec)
    );

    // MC1 model from its maxterm list
    function automatic logic golden_f(input logic [3:0] v);
        return !(v inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd12, 4'd14});
    endfunction

    always_comb begin
        dut_f = golden_f(dut_in);
        case (mode)
            1: dut_f = 1'b0;
            2: dut_f = ~golden_f(dut_in);
            3: dut_f = 1'b1;
            4: dut_f = golden_f(dut_in) ^ (dut_in == 4'd15);
            default: dut_f = golden_f(dut_in);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then watches 120 cycles; cycle 1 is the one after the start edge.
    task automatic run_sweep(input bit repulse, output int done_cyc, output int busy_cyc,
                             output int n_done, output int ord_err);
        done_cyc = -1;
        busy_cyc = 0;
        n_done   = 0;
        ord_err  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            if (busy) begin
                busy_cyc++;
                if (dut_in != 4'((n - 1) / 3)) ord_err++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = n;
            end
            start = repulse && (n == 10 || n == 48 || n == 49);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic wait_vec(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy && dut_in == v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " dut_in"}, dut_in, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " err_count"}, err_count, 0);
        check({tag, " ff_vld"}, first_fail_vld, 0);
        check({tag, " ff_idx"}, first_fail_idx, 0);
        check({tag, " result_vec"}, result_vec, 0);
    endtask

    typedef struct {
        string       name;
        int          mode;
        logic        exp_pass;
        logic [4:0]  exp_err;
        logic        exp_ffv;
        logic [3:0]  exp_ffi;
        logic [15:0] exp_rv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  dc, bc, nd, oe;
        bit  ok;

        vecs[0] = '{"golden",   0, 1'b1, 5'd0,  1'b0, 4'd0,  16'hAAF8};
        vecs[1] = '{"stuck0",   1, 1'b0, 5'd9,  1'b1, 4'd3,  16'h0000};
        vecs[2] = '{"inverted", 2, 1'b0, 5'd16, 1'b1, 4'd0,  16'h5507};
        vecs[3] = '{"stuck1",   3, 1'b0, 5'd7,  1'b1, 4'd0,  16'hFFFF};
        vecs[4] = '{"flip15",   4, 1'b0, 5'd1,  1'b1, 4'd15, 16'h2AF8};

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-sweep at vector 7
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(4'd7, ok);
        check("reach idx7", ok, 1);
        check("idx7 err_count", err_count, 4);
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            run_sweep(1'b0, dc, bc, nd, oe);
            check($sformatf("%s done_cycle", vecs[i].name), dc, 49);
            check($sformatf("%s busy_cycles", vecs[i].name), bc, 48);
            check($sformatf("%s done_pulses", vecs[i].name), nd, 1);
            check($sformatf("%s vector_order", vecs[i].name), oe, 0);
            check($sformatf("%s pass", vecs[i].name), pass, vecs[i].exp_pass);
            check($sformatf("%s err_count", vecs[i].name), err_count, vecs[i].exp_err);
            check($sformatf("%s ff_vld", vecs[i].name), first_fail_vld, vecs[i].exp_ffv);
            check($sformatf("%s ff_idx", vecs[i].name), first_fail_idx, vecs[i].exp_ffi);
            check($sformatf("%s result_vec", vecs[i].name), result_vec, vecs[i].exp_rv);
        end

        // Abort at vector 5 keeps partial results
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(4'd5, ok);
        check("reach idx5", ok, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort dut_in", dut_in, 0);
        check("abort pass", pass, 0);
        check("abort err_count", err_count, 2);
        check("abort ff_vld", first_fail_vld, 1);
        check("abort ff_idx", first_fail_idx, 3);
        check("abort result_vec", result_vec, 16'h0000);
        nd = 0;
        for (int n = 0; n < 60; n++) begin
            if (done || busy) nd++;
            tick();
        end
        check("abort no done/busy", nd, 0);
        mode = 0;
        run_sweep(1'b0, dc, bc, nd, oe);
        check("post-abort done_cycle", dc, 49);
        check("post-abort vector_order", oe, 0);
        check("post-abort pass", pass, 1);

        // start re-pulsed while busy and in DONE
        mode = 2;
        run_sweep(1'b1, dc, bc, nd, oe);
        check("repulse done_pulses", nd, 1);
        check("repulse done_cycle", dc, 49);
        check("repulse busy_cycles", bc, 48);
        check("repulse err_count", err_count, 16);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        nd = 0;
        for (int n = 0; n < 8; n++) begin
            if (busy || done) nd++;
            tick();
        end
        check("start+abort ignored", nd, 0);
        check("start+abort keeps err_count", err_count, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
